fetch_unit: RTL

Instruction fetch stage of the processor; sits directly upstream of decode and the immediate-extension unit. It keeps the fetch PC and issues word reads to instruction memory using a req/ack plus rvalid handshake. Returned words go into a small prefetch queue that presents {instr, instr_pc} to decode with a valid/ready handshake. On a taken branch it redirects to the target computed downstream (PC+8+extended immediate) and flushes the queue.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_queue.sv | 69 ++++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } fetch_state_t;

    localparam logic [31:0] PC_STEP  = 32'd4;
    // Offset used by the downstream branch-target adders (PC+8+imm).
    localparam logic [31:0] PC_AHEAD = 32'd8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory side, decode side and branch redirect.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        branch_taken;
    logic [31:0] branch_target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rvalid, imem_rdata, instr_ready, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rvalid, imem_rdata, instr_ready, branch_taken, branch_target
    );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {instr, pc} entries; head is shown combinationally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    hold_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    // Flush wins over any same-cycle push or pop.
    assign do_push = push_i && !flush_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    // Pointer/count state and a copy of the last shown head for the empty case.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (count_q != '0) begin
                hold_q <= mem_q[rd_ptr_q];
            end
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Entry storage; contents are only visible once pushed, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, single-outstanding memory reads,
// prefetch queue towards decode and branch redirect with response discard.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          discard_q, discard_d;
    logic          push;
    logic          pop;
    logic          flush;
    logic          req;
    logic          instr_valid;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic [31:0]   target;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          unused_tgt_bits;

    assign target          = {bus.branch_target[31:2], 2'b00};
    assign unused_tgt_bits = ^bus.branch_target[1:0];
    assign instr_valid     = (count != '0);
    assign pop             = instr_valid && bus.instr_ready;
    assign push_data       = '{instr: bus.imem_rdata, pc: addr_q};

    // State, fetch PC, held request address and discard flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            discard_q  <= discard_d;
        end
    end

    // Next-state logic; a branch overrides the sequential decisions afterwards.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        addr_d      = addr_q;
        discard_d   = discard_q;
        push        = 1'b0;
        flush       = 1'b0;
        req         = 1'b0;
        count_after = count;

        unique case (state_q)
            IDLE: begin
                if (count < FULL_CNT) begin
                    state_d = REQ;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                req = 1'b1;
                if (bus.imem_ack) begin
                    state_d = RESP;
                    // With discard pending, fetch_pc already holds the redirect target.
                    if (!discard_q) fetch_pc_d = fetch_pc_q + PC_STEP;
                end
            end
            RESP: begin
                if (bus.imem_rvalid) begin
                    push        = !discard_q;
                    discard_d   = 1'b0;
                    count_after = count + CW'(push) - CW'(pop);
                    if (count_after < FULL_CNT) begin
                        state_d = REQ;
                        addr_d  = fetch_pc_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.branch_taken) begin
            flush      = 1'b1;
            push       = 1'b0;
            fetch_pc_d = target;
            unique case (state_q)
                IDLE: begin
                    state_d = REQ;
                    addr_d  = target;
                end
                // A pending request keeps its address; its response is dropped.
                REQ: discard_d = 1'b1;
                RESP: begin
                    if (bus.imem_rvalid) begin
                        discard_d = 1'b0;
                        state_d   = REQ;
                        addr_d    = target;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push),
        .push_data_i(push_data),
        .pop_i      (pop),
        .flush_i    (flush),
        .head_o     (head),
        .count_o    (count)
    );

    assign bus.imem_req    = req;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = instr_valid;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;

endmodule
